// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_ctrl
//  Purpose  : Time-multiplexed scanner for an 8-digit common-anode
//             seven-segment display. Cycles through the eight nibbles of a
//             32-bit display word, inserting an all-off BLANK gap between
//             digits. Word updates take effect only at frame boundaries.
//             Supports per-digit blanking and optional leading-zero
//             suppression.
//  Revision : 1.0  initial release
//
//  Ports
//    clk             system clock, rising edge
//    rst_n           synchronous reset, active-low
//    i_data[31:0]    display word, nibble k -> digit k (digit 0 rightmost)
//    i_load          1-cycle strobe, captures i_data into the pending word
//    i_dp_in[7:0]    decimal-point request per digit, active-high (live)
//    i_digit_en[7:0] per-digit enable, 0 blanks that digit (live)
//    i_lz_en         1 = suppress leading zeros (live)
//    o_nibble[3:0]   hex value of the selected digit, to the decoder
//    o_an[7:0]       anode enables, active-low
//    o_dp            decimal-point segment, active-low
//    o_frame_start   1-cycle pulse on the first SHOW cycle of digit 0
// ============================================================================
module seg_scan_ctrl #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_data,
  input  logic        i_load,
  input  logic [7:0]  i_dp_in,
  input  logic [7:0]  i_digit_en,
  input  logic        i_lz_en,
  output logic [3:0]  o_nibble,
  output logic [7:0]  o_an,
  output logic        o_dp,
  output logic        o_frame_start
);

  localparam int C_CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int C_CNT_W   = (C_CNT_MAX > 2) ? $clog2(C_CNT_MAX) : 1;

  localparam logic [C_CNT_W-1:0] C_SHOW_LAST  = C_CNT_W'(REFRESH_DIV - 1);
  // With BLANK_CYCLES of 0 or 1 the BLANK state always ends after one cycle;
  // the value is then unused.
  localparam logic [C_CNT_W-1:0] C_BLANK_LAST = C_CNT_W'((BLANK_CYCLES > 1) ? BLANK_CYCLES - 1 : 0);
  localparam bit                 C_HAS_BLANK  = (BLANK_CYCLES > 0);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [C_CNT_W-1:0] r_cnt;
  logic [C_CNT_W-1:0] w_cnt_nxt;
  logic [2:0]         r_idx;
  logic [2:0]         w_idx_nxt;
  logic               w_enter_show0;

  logic [31:0]        r_active;
  logic [31:0]        r_pending;
  logic               r_pend_vld;

  logic [31:0]        w_upper;
  logic               w_suppr;
  logic               w_lit;
  logic [3:0]         w_nibble_nxt;
  logic [7:0]         w_an_nxt;
  logic               w_dp_nxt;
  logic               w_fs_nxt;

  // --------------------------------------------------------------------------
  // State, counters, word registers and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_BLANK;
      r_cnt         <= '0;
      r_idx         <= 3'd0;
      r_active      <= 32'd0;
      r_pending     <= 32'd0;
      r_pend_vld    <= 1'b0;
      o_nibble      <= 4'd0;
      o_an          <= 8'hFF;
      o_dp          <= 1'b1;
      o_frame_start <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;

      // Frame-boundary transfer uses the pending value from before this edge,
      // so a coincident load stays pending for the following frame.
      if (w_enter_show0 && r_pend_vld) begin
        r_active <= r_pending;
      end
      if (i_load) begin
        r_pending  <= i_data;
        r_pend_vld <= 1'b1;
      end else if (w_enter_show0) begin
        r_pend_vld <= 1'b0;
      end

      o_nibble      <= w_nibble_nxt;
      o_an          <= w_an_nxt;
      o_dp          <= w_dp_nxt;
      o_frame_start <= w_fs_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt + C_CNT_W'(1);
    w_idx_nxt     = r_idx;
    w_enter_show0 = 1'b0;

    case (r_state)
      ST_BLANK: begin
        if (BLANK_CYCLES <= 1 || r_cnt == C_BLANK_LAST) begin
          w_state_nxt   = ST_SHOW;
          w_cnt_nxt     = '0;
          w_enter_show0 = (r_idx == 3'd0);
        end
      end
      ST_SHOW: begin
        if (r_cnt == C_SHOW_LAST) begin
          w_cnt_nxt = '0;
          w_idx_nxt = r_idx + 3'd1;
          if (C_HAS_BLANK) begin
            w_state_nxt = ST_BLANK;
          end else begin
            // Without a gap, the wrap from digit 7 is itself the frame start.
            w_state_nxt   = ST_SHOW;
            w_enter_show0 = (r_idx == 3'd7);
          end
        end
      end
      default: begin
        w_state_nxt = ST_BLANK;
        w_cnt_nxt   = '0;
      end
    endcase

    // Digit idx is a leading zero when every nibble from idx upward is zero.
    w_upper      = r_active >> {r_idx, 2'b00};
    w_suppr      = i_lz_en && (r_idx != 3'd0) && (w_upper == 32'd0);
    w_lit        = i_digit_en[r_idx] && !w_suppr;

    // The nibble follows idx in both states so the decoder settles in BLANK.
    w_nibble_nxt = w_upper[3:0];
    w_an_nxt     = 8'hFF;
    w_dp_nxt     = 1'b1;
    w_fs_nxt     = 1'b0;
    if (r_state == ST_SHOW) begin
      if (w_lit) begin
        w_an_nxt = ~(8'h01 << r_idx);
        w_dp_nxt = ~i_dp_in[r_idx];
      end
      w_fs_nxt = (r_idx == 3'd0) && (r_cnt == '0);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_scan_ctrl
//  Purpose  : Self-checking bench for seg_scan_ctrl with REFRESH_DIV=4,
//             BLANK_CYCLES=1 (5-cycle digit slot, 40-cycle frame). The
//             stimulus queues the expected output for every cycle; a monitor
//             pops and compares on the falling edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data;
  logic        load;
  logic [7:0]  dp_in;
  logic [7:0]  digit_en;
  logic        lz_en;
  logic [3:0]  nibble;
  logic [7:0]  an;
  logic        dp;
  logic        frame_start;

  seg_scan_ctrl #(
    .REFRESH_DIV (4),
    .BLANK_CYCLES(1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_data       (data),
    .i_load       (load),
    .i_dp_in      (dp_in),
    .i_digit_en   (digit_en),
    .i_lz_en      (lz_en),
    .o_nibble     (nibble),
    .o_an         (an),
    .o_dp         (dp),
    .o_frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] an;
    logic [3:0] nib;
    logic       dp;
    logic       fs;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   n_cycle  = 0;

  localparam exp_t C_RST = '{an: 8'hFF, nib: 4'h0, dp: 1'b1, fs: 1'b0};

  // Monitor: compares whatever the DUT presents against the queued entry.
  always @(negedge clk) begin
    exp_t e;
    exp_t g;
    if (q.size() > 0) begin
      e = q.pop_front();
      g = '{an: an, nib: nibble, dp: dp, fs: frame_start};
      n_checks++;
      if (g !== e) begin
        n_err++;
        $display("FAIL scan[%0d]: got an=%h nib=%h dp=%b fs=%b, want an=%h nib=%h dp=%b fs=%b",
                 n_cycle, g.an, g.nib, g.dp, g.fs, e.an, e.nib, e.dp, e.fs);
      end
      n_cycle++;
    end
  end

  // Expected output for cycle c of a frame: slot d = c/5, BLANK first then
  // 4 SHOW cycles. lit is the hand-computed mask of digits that light up.
  function automatic exp_t mk_entry(input logic [31:0] w, input logic [3:0] p0,
                                    input logic [7:0] lit, input logic [7:0] dpi,
                                    input int c);
    exp_t e;
    int   d;
    int   k;
    d = c / 5;
    k = c % 5;
    e.nib = w[4*d +: 4];
    e.an  = 8'hFF;
    e.dp  = 1'b1;
    e.fs  = 1'b0;
    if (k == 0) begin
      // BLANK of digit 0 is decoded before the frame transfer lands.
      if (d == 0) e.nib = p0;
    end else begin
      if (lit[d]) begin
        e.an = ~(8'h01 << d);
        e.dp = ~dpi[d];
      end
      e.fs = (d == 0) && (k == 1);
    end
    return e;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    q.push_back(C_RST);
    @(posedge clk); #1;
    q.push_back(C_RST);
    rst_n = 1'b1;
  endtask

  // Runs n cycles of one frame; up to three loads at frame offsets la/lb/lc
  // (captured on the following edge, so offset 39 meets the next transfer).
  task automatic run_frame(input logic [31:0] w, input logic [3:0] p0,
                           input logic [7:0] lit, input logic [7:0] den,
                           input logic [7:0] dpi, input logic lz, input int n,
                           input int la, input logic [31:0] da,
                           input int lb, input logic [31:0] db,
                           input int lc, input logic [31:0] dc);
    digit_en = den;
    dp_in    = dpi;
    lz_en    = lz;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      q.push_back(mk_entry(w, p0, lit, dpi, c));
      load = 1'b0;
      if (c == la) begin data = da; load = 1'b1; end
      if (c == lb) begin data = db; load = 1'b1; end
      if (c == lc) begin data = dc; load = 1'b1; end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n    = 1'b0;
    data     = 32'd0;
    load     = 1'b0;
    dp_in    = 8'h00;
    digit_en = 8'hFF;
    lz_en    = 1'b0;

    do_reset();
    // F0: blank word, load 76543210 for the next frame
    run_frame(32'h0, 4'h0, 8'hFF, 8'hFF, 8'h00, 1'b0, 40,
              10, 32'h76543210, -1, 32'h0, -1, 32'h0);
    // F1: 76543210 scanned; load ABCD while digit 3 is lit
    run_frame(32'h76543210, 4'h0, 8'hFF, 8'hFF, 8'h00, 1'b0, 40,
              17, 32'h0000ABCD, -1, 32'h0, -1, 32'h0);
    // F2: ABCD shows D,C,B,A,0,0,0,0; queue 00000120
    run_frame(32'h0000ABCD, 4'h0, 8'hFF, 8'hFF, 8'h00, 1'b0, 40,
              5, 32'h00000120, -1, 32'h0, -1, 32'h0);
    // F3: leading-zero suppression leaves digits 0..2 lit
    run_frame(32'h00000120, 4'hD, 8'h07, 8'hFF, 8'h00, 1'b1, 40,
              8, 32'h00000000, -1, 32'h0, -1, 32'h0);
    // F4: all-zero word with suppression: only digit 0 lit
    run_frame(32'h0, 4'h0, 8'h01, 8'hFF, 8'h00, 1'b1, 40,
              -1, 32'h0, -1, 32'h0, -1, 32'h0);
    // F5: digit_en=AA, dp on digit 1; two loads, then one at the boundary
    run_frame(32'h0, 4'h0, 8'hAA, 8'hAA, 8'h02, 1'b0, 40,
              3, 32'h11111111, 20, 32'h22222222, 39, 32'h33333333);
    // F6: last load of F5 wins
    run_frame(32'h22222222, 4'h0, 8'hFF, 8'hFF, 8'h00, 1'b0, 40,
              -1, 32'h0, -1, 32'h0, -1, 32'h0);
    // F7: boundary load shows one frame later
    run_frame(32'h33333333, 4'h2, 8'hFF, 8'hFF, 8'h00, 1'b0, 40,
              -1, 32'h0, -1, 32'h0, -1, 32'h0);
    // F8: stop during SHOW of digit 5, then reset mid-scan
    run_frame(32'h33333333, 4'h3, 8'hFF, 8'hFF, 8'h00, 1'b0, 28,
              -1, 32'h0, -1, 32'h0, -1, 32'h0);
    do_reset();
    // F9: scanning restarts at digit 0 with a cleared word
    run_frame(32'h0, 4'h0, 8'hFF, 8'hFF, 8'h00, 1'b0, 40,
              -1, 32'h0, -1, 32'h0, -1, 32'h0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_err++;
      $display("FAIL drain: got %0d entries left, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
